// File: rtl/fm_demod_pkg.sv
// Shared state type, output width and saturation helper for the zero-crossing FM demodulator.
package fm_demod_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        LOW     = 2'd1,
        HIGH    = 2'd2
    } zc_state_e;

    localparam int OUT_W  = 18;
    localparam int WIDE_W = 48;

    localparam logic signed [OUT_W-1:0] SAT_MAX = 18'sh1FFFF;
    localparam logic signed [OUT_W-1:0] SAT_MIN = 18'sh20000;

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [WIDE_W-1:0] v);
        logic signed [OUT_W-1:0] r;
        if (v > 48'sd131071) begin
            r = SAT_MAX;
        end else if (v < -48'sd131072) begin
            r = SAT_MIN;
        end else begin
            r = v[OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/zc_period_avg.sv
// Four-entry period history with running sum; avg/avg_ready reflect the period being pushed this cycle.
module zc_period_avg #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] avg,
    output logic             avg_ready
);

    logic [CNT_W-1:0] hist_r [4];
    logic [CNT_W+1:0] sum_r;
    logic [CNT_W+1:0] sum_s;
    logic [1:0]       fill_r;

    // Sum after retiring the oldest entry and adding the incoming period
    always_comb begin
        sum_s = sum_r - {2'b00, hist_r[3]} + {2'b00, period};
    end

    assign avg       = CNT_W'(sum_s >> 2);
    assign avg_ready = push && (fill_r == 2'd3);

    // History shift register, running sum and fill level
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            for (int i = 0; i < 4; i++) begin
                hist_r[i] <= {CNT_W{1'b0}};
            end
            sum_r  <= {(CNT_W+2){1'b0}};
            fill_r <= 2'd0;
        end else if (push) begin
            hist_r[3] <= hist_r[2];
            hist_r[2] <= hist_r[1];
            hist_r[1] <= hist_r[0];
            hist_r[0] <= period;
            sum_r     <= sum_s;
            if (fill_r != 2'd3) begin
                fill_r <= fill_r + 2'd1;
            end else begin
                fill_r <= fill_r;
            end
        end else begin
            sum_r <= sum_r;
        end
    end

endmodule

// File: rtl/fm_zc_demod.sv
// Zero-crossing FM demodulator: rising-crossing period -> saturated 18-bit deviation.
// Optional FM_ZC_DEMOD_AVG_EN averages the last four periods before scaling.
module fm_zc_demod
    import fm_demod_pkg::*;
#(
    parameter int DIN_W      = 8,
    parameter int CNT_W      = 16,
    parameter int HYST       = 4,
    parameter int NOMINAL    = 100,
    parameter int TIMEOUT    = 400,
    parameter int GAIN_SHIFT = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    din_valid,
    input  logic signed [DIN_W-1:0] din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_valid,
    output logic                    carrier_lost
);

    localparam logic signed [DIN_W-1:0] HYST_POS = DIN_W'(HYST);
    localparam logic signed [DIN_W-1:0] HYST_NEG = DIN_W'(-HYST);
    localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]        CNT_TMO  = CNT_W'(TIMEOUT);
    localparam logic signed [CNT_W:0]   NOM_V    = (CNT_W+1)'(NOMINAL);

    zc_state_e                state_r, state_s;
    logic [CNT_W-1:0]         cnt_r, cnt_s, period_s;
    logic signed [OUT_W-1:0]  dout_r;
    logic                     dout_valid_r, carrier_lost_r;
    logic                     above_s, below_s, rise_s, timeout_s, meas_s, fire_s;
    logic signed [CNT_W:0]    dev_s;
    logic signed [WIDE_W-1:0] dev_wide_s, scaled_s;

    assign above_s   = din >= HYST_POS;
    assign below_s   = din <= HYST_NEG;
    assign rise_s    = din_valid && (state_r == LOW) && above_s;
    // A crossing on the timeout sample takes priority over the timeout
    assign timeout_s = din_valid && !carrier_lost_r && !rise_s && (cnt_r == CNT_TMO);
    assign meas_s    = rise_s && !carrier_lost_r;

    // Hysteresis FSM next state
    always_comb begin
        state_s = state_r;
        if (timeout_s) begin
            state_s = ACQUIRE;
        end else if (din_valid) begin
            case (state_r)
                ACQUIRE: if (below_s) state_s = LOW;  else state_s = ACQUIRE;
                LOW:     if (above_s) state_s = HIGH; else state_s = LOW;
                HIGH:    if (below_s) state_s = LOW;  else state_s = HIGH;
                default: state_s = ACQUIRE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Period counter: restarts on each crossing, runs only while locked, saturates at TIMEOUT
    always_comb begin
        cnt_s = cnt_r;
        if (rise_s) begin
            cnt_s = CNT_ONE;
        end else if (timeout_s) begin
            cnt_s = {CNT_W{1'b0}};
        end else if (din_valid && !carrier_lost_r && (cnt_r != CNT_TMO)) begin
            cnt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_s = cnt_r;
        end
    end

`ifdef FM_ZC_DEMOD_AVG_EN
    logic [CNT_W-1:0] avg_s;
    logic             avg_ready_s;

    zc_period_avg #(
        .CNT_W (CNT_W)
    ) u_avg (
        .clock     (clock),
        .reset     (reset),
        .clear     (timeout_s),
        .push      (meas_s),
        .period    (cnt_r),
        .avg       (avg_s),
        .avg_ready (avg_ready_s)
    );

    assign period_s = avg_s;
    assign fire_s   = avg_ready_s;
`else
    assign period_s = cnt_r;
    assign fire_s   = meas_s;
`endif

    assign dev_s      = NOM_V - $signed({1'b0, period_s});
    assign dev_wide_s = {{(WIDE_W-CNT_W-1){dev_s[CNT_W]}}, dev_s};
    assign scaled_s   = dev_wide_s <<< GAIN_SHIFT;

    // State, counter and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r        <= ACQUIRE;
            cnt_r          <= {CNT_W{1'b0}};
            dout_r         <= {OUT_W{1'b0}};
            dout_valid_r   <= 1'b0;
            carrier_lost_r <= 1'b1;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            dout_valid_r <= fire_s;
            if (fire_s) begin
                dout_r <= sat_out(scaled_s);
            end else begin
                dout_r <= dout_r;
            end
            if (rise_s) begin
                carrier_lost_r <= 1'b0;
            end else if (timeout_s) begin
                carrier_lost_r <= 1'b1;
            end else begin
                carrier_lost_r <= carrier_lost_r;
            end
        end
    end

    assign dout         = dout_r;
    assign dout_valid   = dout_valid_r;
    assign carrier_lost = carrier_lost_r;

endmodule

// File: tb/tb_fm_zc_demod.sv
// Randomised bench for fm_zc_demod: a generator with known crossing intervals drives two
// instances (default, and GAIN_SHIFT=11/TIMEOUT=500) checked against a period-level model.
module tb_fm_zc_demod;

    localparam int NOMINAL = 100;

    logic              clock = 1'b0;
    logic              reset;
    logic              din_valid;
    logic signed [7:0] din;
    logic signed [17:0] dout0, dout1;
    logic              dv0, dv1, cl0, cl1;

    always #5 clock = ~clock;

    fm_zc_demod dut0 (
        .clock(clock), .reset(reset), .din_valid(din_valid), .din(din),
        .dout(dout0), .dout_valid(dv0), .carrier_lost(cl0)
    );

    fm_zc_demod #(.GAIN_SHIFT(11), .TIMEOUT(500)) dut1 (
        .clock(clock), .reset(reset), .din_valid(din_valid), .din(din),
        .dout(dout1), .dout_valid(dv1), .carrier_lost(cl1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int tmo[2];
    int gsh[2];
    bit locked[2];
    int since[2];
    int hist[2][4];
    int hcnt[2];
    bit exp_dv[2];
    int exp_dout[2];
    bit exp_cl[2];

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int scale(input int p, input int g);
        longint v;
        v = longint'(NOMINAL - p) * (longint'(1) << g);
        if (v > 131071) v = 131071;
        if (v < -131072) v = -131072;
        return int'(v);
    endfunction

    function automatic logic signed [7:0] rhi();
        int v;
        v = int'($urandom_range(127, 4));
        return 8'(v);
    endfunction

    function automatic logic signed [7:0] rlo();
        int v;
        v = -int'($urandom_range(128, 4));
        return 8'(v);
    endfunction

    function automatic logic signed [7:0] rin();
        int v;
        v = int'($urandom_range(6, 0)) - 3;
        return 8'(v);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            locked[d] = 1'b0; since[d] = 0; hcnt[d] = 0;
            exp_dv[d] = 1'b0; exp_dout[d] = 0; exp_cl[d] = 1'b1;
        end
    endtask

    // is_cross marks the generator's intended rising crossing (first high after a real low)
    task automatic model_sample(input bit is_cross);
        for (int d = 0; d < 2; d++) begin
            exp_dv[d] = 1'b0;
            if (is_cross) begin
                if (locked[d]) begin
                    int p;
                    p = since[d] + 1;
`ifdef FM_ZC_DEMOD_AVG_EN
                    for (int k = 3; k > 0; k--) hist[d][k] = hist[d][k-1];
                    hist[d][0] = p;
                    if (hcnt[d] < 4) hcnt[d]++;
                    if (hcnt[d] == 4) begin
                        exp_dv[d] = 1'b1;
                        exp_dout[d] = scale((hist[d][0] + hist[d][1] + hist[d][2] + hist[d][3]) / 4, gsh[d]);
                    end
`else
                    exp_dv[d] = 1'b1;
                    exp_dout[d] = scale(p, gsh[d]);
`endif
                end else begin
                    locked[d] = 1'b1;
                    exp_cl[d] = 1'b0;
                end
                since[d] = 0;
            end else if (locked[d]) begin
                since[d]++;
                if (since[d] == tmo[d]) begin
                    locked[d] = 1'b0;
                    exp_cl[d] = 1'b1;
                    hcnt[d] = 0;
                end
            end
        end
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "dv0"},   int'(dv0),   int'(exp_dv[0]));
        chk({pfx, "dout0"}, int'(dout0), exp_dout[0]);
        chk({pfx, "lost0"}, int'(cl0),   int'(exp_cl[0]));
        chk({pfx, "dv1"},   int'(dv1),   int'(exp_dv[1]));
        chk({pfx, "dout1"}, int'(dout1), exp_dout[1]);
        chk({pfx, "lost1"}, int'(cl1),   int'(exp_cl[1]));
    endtask

    task automatic send(input logic signed [7:0] x, input bit is_cross);
        if ($urandom_range(9, 0) == 0) begin
            @(negedge clock);
            din_valid = 1'b0;
            din = 8'($urandom);
            @(posedge clock); #1;
            chk("idle_dv0", int'(dv0), 0);
            chk("idle_dv1", int'(dv1), 0);
        end
        @(negedge clock);
        din = x;
        din_valid = 1'b1;
        model_sample(is_cross);
        @(posedge clock); #1;
        check_outputs("");
    endtask

    // One crossing followed by P-1 samples, so the next crossing is exactly P samples later
    task automatic run_period(input int p, input bit hold);
        int h;
        send(hold ? 8'sd64 : rhi(), 1'b1);
        h = hold ? p : int'($urandom_range(p - 1, 0));
        for (int k = 1; k < p; k++) begin
            logic signed [7:0] x;
            if (k == p - 1 || (k == p - 2 && p > 2)) x = hold ? -8'sd64 : rlo();
            else if (hold) x = 8'sd64;
            else if ($urandom_range(7, 0) == 0) x = rin();
            else if (k <= h) x = rhi();
            else x = rlo();
            send(x, 1'b0);
        end
    endtask

    initial begin
        tmo[0] = 400; gsh[0] = 8;
        tmo[1] = 500; gsh[1] = 11;
        reset = 1'b0; din_valid = 1'b0; din = 8'sd0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_outputs("rst_");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check_outputs("rel_");

        repeat (3) send(rlo(), 1'b0);
        repeat (4) run_period(100, 1'b0);
        run_period(96, 1'b0);  run_period(96, 1'b0);
        run_period(104, 1'b0); run_period(104, 1'b0);
        run_period(100, 1'b0);
        repeat (30) run_period(int'($urandom_range(200, 2)), 1'b0);
        repeat (5) run_period(2, 1'b0);
        run_period(400, 1'b0);
        run_period(450, 1'b0);
        run_period(420, 1'b1);
        run_period(600, 1'b1);
        repeat (6) run_period(100, 1'b0);

        // Reset lands on a crossing sample: the pending output must be discarded
        @(negedge clock);
        reset = 1'b0; din = 8'sd64; din_valid = 1'b1;
        model_reset();
        @(posedge clock); #1;
        check_outputs("midrst_");
        @(negedge clock);
        reset = 1'b1; din_valid = 1'b0;

        repeat (3) send(rlo(), 1'b0);
        repeat (6) run_period(int'($urandom_range(120, 80)), 1'b0);
        run_period(100, 1'b0);
        send(rhi(), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
